// File: rtl/mem_stage_sized_if.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_sized_if
// Brief   : EX/MEM request bundle and MEM/WB result bundle of the MEM stage.
// Revision: 1.0  initial release
// ============================================================================
interface mem_stage_sized_if;
   logic        ex_mem_readmem;
   logic        ex_mem_writemem;
   logic [1:0]  ex_mem_size;
   logic        ex_mem_unsigned;
   logic [31:0] ex_mem_regb;
   logic        ex_mem_selwsource;
   logic [4:0]  ex_mem_regdest;
   logic        ex_mem_writereg;
   logic [31:0] ex_mem_wbvalue;
   logic        mem_stall;
   logic        mem_misaligned;
   logic [4:0]  mem_wb_regdest;
   logic        mem_wb_writereg;
   logic [31:0] mem_wb_wbvalue;

   modport master (
      output ex_mem_readmem, ex_mem_writemem, ex_mem_size, ex_mem_unsigned,
             ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg,
             ex_mem_wbvalue,
      input  mem_stall, mem_misaligned, mem_wb_regdest, mem_wb_writereg,
             mem_wb_wbvalue
   );

   modport slave (
      input  ex_mem_readmem, ex_mem_writemem, ex_mem_size, ex_mem_unsigned,
             ex_mem_regb, ex_mem_selwsource, ex_mem_regdest, ex_mem_writereg,
             ex_mem_wbvalue,
      output mem_stall, mem_misaligned, mem_wb_regdest, mem_wb_writereg,
             mem_wb_wbvalue
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_sized.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_sized
// Brief   : Pipeline MEM stage with sized loads/stores, misalignment drop and
//           a configurable wait-state FSM stalling upstream.
// Revision: 1.0  initial release
// ============================================================================
module mem_stage_sized #(
   parameter int ADDR_W      = 7,
   parameter int WAIT_STATES = 0
) (
   input wire clock,
   input wire reset,
   mem_stage_sized_if.slave bus
);
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam logic [3:0] c_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic       c_HAS_WAIT = (WAIT_STATES > 0);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [4:0]  r_regdest;
   logic        r_writereg;
   logic [31:0] r_wbvalue;
   logic        r_misaligned;
   logic [31:0] r_mem [0:(2**ADDR_W)-1];

   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic              w_is_load, w_is_store, w_mem_op;
   logic              w_is_byte, w_is_half, w_is_word;
   logic              w_misaligned, w_access, w_complete, w_emit, w_we, w_stall;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata, w_rd_word, w_load_val, w_wb_next;
   logic [7:0]        w_sel_byte;
   logic [15:0]       w_sel_half;
   logic              w_unused_addr;

   assign w_idx         = bus.ex_mem_wbvalue[ADDR_W+1:2];
   assign w_lane        = bus.ex_mem_wbvalue[1:0];
   assign w_unused_addr = ^bus.ex_mem_wbvalue[31:ADDR_W+2];

   assign w_is_store = bus.ex_mem_writemem;
   assign w_is_load  = bus.ex_mem_readmem & ~bus.ex_mem_writemem;
   assign w_mem_op   = bus.ex_mem_readmem | bus.ex_mem_writemem;
   assign w_is_byte  = (bus.ex_mem_size == 2'b00);
   assign w_is_half  = (bus.ex_mem_size == 2'b01);
   assign w_is_word  = bus.ex_mem_size[1];

   assign w_misaligned = w_mem_op & ((w_is_half & w_lane[0]) | (w_is_word & (|w_lane)));
   assign w_access     = w_mem_op & ~w_misaligned;

   // In WAIT the held inputs are an aligned access by upstream contract.
   assign w_complete = (r_state == S_WAIT) ? (r_cnt == 4'd0) : (w_access & ~c_HAS_WAIT);
   assign w_emit     = (r_state == S_WAIT) ? (r_cnt == 4'd0)
                                           : ~w_misaligned & ~(w_access & c_HAS_WAIT);
   assign w_stall    = reset & (((r_state == S_IDLE) & w_access & c_HAS_WAIT) |
                                ((r_state == S_WAIT) & (r_cnt != 4'd0)));
   assign w_we       = reset & w_complete & w_is_store & w_access;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = bus.ex_mem_regb;
      if (w_is_byte) begin
         w_be    = 4'b0001 << w_lane;
         w_wdata = {4{bus.ex_mem_regb[7:0]}};
      end else if (w_is_half) begin
         w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{bus.ex_mem_regb[15:0]}};
      end
   end

   always_ff @(posedge clock) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   assign w_rd_word = r_mem[w_idx];

   always_comb begin
      case (w_lane)
         2'd0:    w_sel_byte = w_rd_word[7:0];
         2'd1:    w_sel_byte = w_rd_word[15:8];
         2'd2:    w_sel_byte = w_rd_word[23:16];
         default: w_sel_byte = w_rd_word[31:24];
      endcase
      w_sel_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      w_load_val = w_rd_word;
      if (w_is_byte)
         w_load_val = bus.ex_mem_unsigned ? {24'd0, w_sel_byte}
                                          : {{24{w_sel_byte[7]}}, w_sel_byte};
      else if (w_is_half)
         w_load_val = bus.ex_mem_unsigned ? {16'd0, w_sel_half}
                                          : {{16{w_sel_half[15]}}, w_sel_half};
   end

   assign w_wb_next = (w_is_load & bus.ex_mem_selwsource) ? w_load_val : bus.ex_mem_wbvalue;

   // Any cycle that does not emit a completed op pushes a bubble into MEM/WB.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_regdest    <= 5'd0;
         r_writereg   <= 1'b0;
         r_wbvalue    <= 32'd0;
         r_misaligned <= 1'b0;
      end else begin
         r_regdest    <= w_emit ? bus.ex_mem_regdest  : 5'd0;
         r_writereg   <= w_emit ? bus.ex_mem_writereg : 1'b0;
         r_wbvalue    <= w_emit ? w_wb_next           : 32'd0;
         r_misaligned <= (r_state == S_IDLE) & w_misaligned;
         case (r_state)
            S_IDLE: begin
               if (w_access && c_HAS_WAIT) begin
                  r_cnt   <= c_CNT_INIT;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != 4'd0) r_cnt   <= r_cnt - 4'd1;
               else               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_stall       = w_stall;
   assign bus.mem_misaligned  = r_misaligned;
   assign bus.mem_wb_regdest  = r_regdest;
   assign bus.mem_wb_writereg = r_writereg;
   assign bus.mem_wb_wbvalue  = r_wbvalue;
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sized.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_sized
// Brief   : Directed bench for mem_stage_sized, zero-wait and 3-wait instances.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_stage_sized;
   logic clk    = 1'b0;
   logic rst_n0 = 1'b0;
   logic rst_n3 = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   mem_stage_sized_if if0 ();
   mem_stage_sized_if if3 ();

   mem_stage_sized #(.ADDR_W(7), .WAIT_STATES(0)) u_dut0 (.clock(clk), .reset(rst_n0), .bus(if0));
   mem_stage_sized #(.ADDR_W(7), .WAIT_STATES(3)) u_dut3 (.clock(clk), .reset(rst_n3), .bus(if3));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Apply one op to the zero-wait instance and advance past its edge.
   task automatic op0(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] b, input logic sel, input logic [4:0] dst,
                      input logic wreg, input logic [31:0] v);
      if0.ex_mem_readmem = rd;   if0.ex_mem_writemem = wr;  if0.ex_mem_size = sz;
      if0.ex_mem_unsigned = uns; if0.ex_mem_regb = b;       if0.ex_mem_selwsource = sel;
      if0.ex_mem_regdest = dst;  if0.ex_mem_writereg = wreg; if0.ex_mem_wbvalue = v;
      #1;
      check("stall0", {31'd0, if0.mem_stall}, 32'd0);
      @(posedge clk); #1;
   endtask

   // Apply one op to the 3-wait instance, holding it through the expected stalls.
   task automatic op3(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] b, input logic sel, input logic [4:0] dst,
                      input logic wreg, input logic [31:0] v, input int waits);
      if3.ex_mem_readmem = rd;   if3.ex_mem_writemem = wr;  if3.ex_mem_size = sz;
      if3.ex_mem_unsigned = uns; if3.ex_mem_regb = b;       if3.ex_mem_selwsource = sel;
      if3.ex_mem_regdest = dst;  if3.ex_mem_writereg = wreg; if3.ex_mem_wbvalue = v;
      #1;
      for (int i = 0; i < waits; i++) begin
         check("stall3_hi", {31'd0, if3.mem_stall}, 32'd1);
         @(posedge clk); #1;
         check("bubble_wr", {31'd0, if3.mem_wb_writereg}, 32'd0);
         check("bubble_val", if3.mem_wb_wbvalue, 32'd0);
      end
      check("stall3_lo", {31'd0, if3.mem_stall}, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      op_init();
      repeat (2) @(posedge clk);
      #1;
      check("rst_regdest", {27'd0, if0.mem_wb_regdest}, 32'd0);
      check("rst_writereg", {31'd0, if0.mem_wb_writereg}, 32'd0);
      check("rst_wbvalue", if0.mem_wb_wbvalue, 32'd0);
      check("rst_misal", {31'd0, if0.mem_misaligned}, 32'd0);
      check("rst_stall3", {31'd0, if3.mem_stall}, 32'd0);
      rst_n0 = 1'b1;
      rst_n3 = 1'b1;

      // pass-through
      op0(0, 0, 2'b10, 0, 32'h0, 0, 5'd5, 1, 32'h1234_5678);
      check("pt_regdest", {27'd0, if0.mem_wb_regdest}, 32'd5);
      check("pt_writereg", {31'd0, if0.mem_wb_writereg}, 32'd1);
      check("pt_wbvalue", if0.mem_wb_wbvalue, 32'h1234_5678);

      // sub-word loads and byte-lane stores
      op0(0, 1, 2'b10, 0, 32'hA1B2_C3D4, 0, 5'd0, 0, 32'h8);
      check("st_wbvalue", if0.mem_wb_wbvalue, 32'h8);
      op0(1, 0, 2'b00, 0, 32'h0, 1, 5'd3, 1, 32'hB);
      check("ldb_s", if0.mem_wb_wbvalue, 32'hFFFF_FFA1);
      check("ldb_dst", {27'd0, if0.mem_wb_regdest}, 32'd3);
      op0(1, 0, 2'b01, 1, 32'h0, 1, 5'd4, 1, 32'hA);
      check("ldh_u", if0.mem_wb_wbvalue, 32'h0000_A1B2);
      op0(0, 1, 2'b00, 0, 32'hDEAD_BE55, 0, 5'd0, 0, 32'h9);
      op0(1, 0, 2'b10, 0, 32'h0, 1, 5'd4, 1, 32'h8);
      check("ldw_merge", if0.mem_wb_wbvalue, 32'hA1B2_55D4);
      op0(1, 0, 2'b00, 0, 32'h0, 1, 5'd4, 1, 32'h8);
      check("ldb_s_lane0", if0.mem_wb_wbvalue, 32'hFFFF_FFD4);
      op0(0, 1, 2'b01, 0, 32'h1234_8001, 0, 5'd0, 0, 32'hA);
      op0(1, 0, 2'b01, 0, 32'h0, 1, 5'd4, 1, 32'hA);
      check("ldh_s_hi", if0.mem_wb_wbvalue, 32'hFFFF_8001);
      op0(1, 0, 2'b10, 0, 32'h0, 0, 5'd4, 1, 32'h8);
      check("ld_selalu", if0.mem_wb_wbvalue, 32'h8);
      op0(1, 1, 2'b10, 0, 32'h0F0F_0F0F, 1, 5'd7, 1, 32'hC);
      check("rdwr_store", if0.mem_wb_wbvalue, 32'hC);
      op0(1, 0, 2'b10, 0, 32'h0, 1, 5'd7, 1, 32'hC);
      check("rdwr_ldw", if0.mem_wb_wbvalue, 32'h0F0F_0F0F);

      // misalignment
      op0(0, 1, 2'b10, 0, 32'h1122_3344, 0, 5'd0, 0, 32'h4);
      op0(1, 0, 2'b10, 0, 32'h0, 1, 5'd9, 1, 32'h6);
      check("mis_flag", {31'd0, if0.mem_misaligned}, 32'd1);
      check("mis_writereg", {31'd0, if0.mem_wb_writereg}, 32'd0);
      check("mis_regdest", {27'd0, if0.mem_wb_regdest}, 32'd0);
      check("mis_wbvalue", if0.mem_wb_wbvalue, 32'd0);
      op0(0, 0, 2'b10, 0, 32'h0, 0, 5'd2, 1, 32'h77);
      check("mis_clear", {31'd0, if0.mem_misaligned}, 32'd0);
      check("mis_next_pt", if0.mem_wb_wbvalue, 32'h77);
      op0(0, 1, 2'b01, 0, 32'h0000_FFFF, 0, 5'd0, 0, 32'h5);
      check("mis_st_flag", {31'd0, if0.mem_misaligned}, 32'd1);
      op0(1, 0, 2'b10, 0, 32'h0, 1, 5'd9, 1, 32'h4);
      check("mis_ram_kept", if0.mem_wb_wbvalue, 32'h1122_3344);
      op0(1, 0, 2'b00, 1, 32'h0, 1, 5'd9, 1, 32'h7);
      check("ldb_u_lane3", if0.mem_wb_wbvalue, 32'h0000_0011);

      // address wrap and reserved size
      op0(0, 1, 2'b10, 0, 32'hCAFE_F00D, 0, 5'd0, 0, 32'h200);
      op0(1, 0, 2'b11, 0, 32'h0, 1, 5'd1, 1, 32'h0);
      check("wrap_ldw", if0.mem_wb_wbvalue, 32'hCAFE_F00D);

      // wait states
      op3(0, 1, 2'b10, 0, 32'h0BAD_BEEF, 0, 5'd0, 0, 32'h10, 3);
      check("ws_st_val", if3.mem_wb_wbvalue, 32'h10);
      op3(1, 0, 2'b10, 0, 32'h0, 1, 5'd6, 1, 32'h10, 3);
      check("ws_ld_val", if3.mem_wb_wbvalue, 32'h0BAD_BEEF);
      check("ws_ld_dst", {27'd0, if3.mem_wb_regdest}, 32'd6);
      check("ws_ld_wr", {31'd0, if3.mem_wb_writereg}, 32'd1);
      op3(0, 0, 2'b10, 0, 32'h0, 0, 5'd8, 1, 32'h99, 0);
      check("ws_pt_val", if3.mem_wb_wbvalue, 32'h99);
      op3(1, 0, 2'b01, 0, 32'h0, 1, 5'd8, 1, 32'h11, 0);
      check("ws_mis_flag", {31'd0, if3.mem_misaligned}, 32'd1);
      check("ws_mis_wr", {31'd0, if3.mem_wb_writereg}, 32'd0);

      // reset during WAIT aborts the store
      if3.ex_mem_readmem = 0;  if3.ex_mem_writemem = 1; if3.ex_mem_size = 2'b10;
      if3.ex_mem_regb = 32'h1234_5678; if3.ex_mem_selwsource = 0;
      if3.ex_mem_regdest = 5'd3; if3.ex_mem_writereg = 1; if3.ex_mem_wbvalue = 32'h10;
      @(posedge clk); #1;
      check("abort_stall_hi", {31'd0, if3.mem_stall}, 32'd1);
      rst_n3 = 1'b0;
      #1;
      check("abort_stall_lo", {31'd0, if3.mem_stall}, 32'd0);
      check("abort_writereg", {31'd0, if3.mem_wb_writereg}, 32'd0);
      check("abort_wbvalue", if3.mem_wb_wbvalue, 32'd0);
      repeat (4) @(posedge clk);
      #2;
      check("abort_hold_wb", if3.mem_wb_wbvalue, 32'd0);
      if3.ex_mem_writemem = 0;
      rst_n3 = 1'b1;
      op3(1, 0, 2'b10, 0, 32'h0, 1, 5'd6, 1, 32'h10, 3);
      check("abort_ram_old", if3.mem_wb_wbvalue, 32'h0BAD_BEEF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   task automatic op_init();
      if0.ex_mem_readmem = 0; if0.ex_mem_writemem = 0; if0.ex_mem_size = 2'b10;
      if0.ex_mem_unsigned = 0; if0.ex_mem_regb = 0; if0.ex_mem_selwsource = 0;
      if0.ex_mem_regdest = 0; if0.ex_mem_writereg = 0; if0.ex_mem_wbvalue = 0;
      if3.ex_mem_readmem = 0; if3.ex_mem_writemem = 0; if3.ex_mem_size = 2'b10;
      if3.ex_mem_unsigned = 0; if3.ex_mem_regb = 0; if3.ex_mem_selwsource = 0;
      if3.ex_mem_regdest = 0; if3.ex_mem_writereg = 0; if3.ex_mem_wbvalue = 0;
   endtask
endmodule
`default_nettype wire
